// File: rtl/vram_port_arbiter.sv
// Single-port VRAM responder: display reads own every slot they ask for,
// posted CPU writes and a single outstanding CPU read fill the idle slots.
module vram_port_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 8,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic                           PIX_CLK,
  input  logic                           RESET_N,
  input  logic                           VID_RD,
  input  logic [ADDR_W-1:0]              VID_ADDR,
  output logic [DATA_W-1:0]              VID_DATA,
  output logic                           VID_VALID,
  input  logic                           CPU_REQ,
  input  logic                           CPU_WE,
  input  logic [ADDR_W-1:0]              CPU_ADDR,
  input  logic [DATA_W-1:0]              CPU_WDATA,
  output logic [DATA_W-1:0]              CPU_RDATA,
  output logic                           CPU_ACK,
  output logic [$clog2(WFIFO_DEPTH):0]   WFIFO_LVL,
  output logic                           RAM_CE,
  output logic                           RAM_WE,
  output logic [ADDR_W-1:0]              RAM_ADDR,
  output logic [DATA_W-1:0]              RAM_WDATA,
  input  logic [DATA_W-1:0]              RAM_RDATA
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(WFIFO_DEPTH);

  typedef enum logic [1:0] {
    C_IDLE     = 2'd0,
    C_RDPEND   = 2'd1,
    C_RDFLIGHT = 2'd2
  } cpu_state_t;

  cpu_state_t state, state_nxt;

  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [ADDR_W-1:0] rd_addr;

  // Slot-ownership tags: tag0 = RAM cycle now being presented, tag1 = its data now on RAM_RDATA
  logic vid_tag0, vid_tag1;
  logic cpu_tag0, cpu_tag1;

  logic fifo_empty, fifo_full;
  logic wr_accept, rd_accept;
  logic grant_vid, grant_wr, grant_rd;
  logic rd_done;

  // Acceptance, slot arbitration and CPU read FSM next-state
  always_comb begin
    fifo_empty = (WFIFO_LVL == '0);
    fifo_full  = (WFIFO_LVL == LVL_FULL);
    // Full is judged on the pre-edge level, so a same-edge pop does not make room
    wr_accept  = CPU_REQ && CPU_WE && !CPU_ACK && (state == C_IDLE) && !fifo_full;
    rd_accept  = CPU_REQ && !CPU_WE && !CPU_ACK && (state == C_IDLE);
    grant_vid  = VID_RD;
    grant_wr   = !VID_RD && !fifo_empty;
    // Reads wait for the FIFO to drain so read-after-write sees the new data
    grant_rd   = !VID_RD && fifo_empty && (state == C_RDPEND);
    rd_done    = cpu_tag1;
    state_nxt  = state;
    case (state)
      C_IDLE:     if (rd_accept) state_nxt = C_RDPEND;
      C_RDPEND:   if (grant_rd)  state_nxt = C_RDFLIGHT;
      C_RDFLIGHT: if (rd_done)   state_nxt = C_IDLE;
      default:    state_nxt = C_IDLE;
    endcase
  end

  // CPU read FSM state register
  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) state <= C_IDLE;
    else          state <= state_nxt;
  end

  // Registered RAM port; address/data hold when no slot is granted
  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RAM_CE    <= 1'b0;
      RAM_WE    <= 1'b0;
      RAM_ADDR  <= '0;
      RAM_WDATA <= '0;
    end else begin
      RAM_CE <= grant_vid | grant_wr | grant_rd;
      RAM_WE <= grant_wr;
      if (grant_vid) begin
        RAM_ADDR <= VID_ADDR;
      end else if (grant_wr) begin
        RAM_ADDR  <= fifo_addr[rptr];
        RAM_WDATA <= fifo_data[rptr];
      end else if (grant_rd) begin
        RAM_ADDR <= rd_addr;
      end
    end
  end

  // Posted-write FIFO storage (contents are don't-care once pointers reset)
  always_ff @(posedge PIX_CLK) begin
    if (wr_accept) begin
      fifo_addr[wptr] <= CPU_ADDR;
      fifo_data[wptr] <= CPU_WDATA;
    end
  end

  // Posted-write FIFO pointers and occupancy
  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr      <= '0;
      rptr      <= '0;
      WFIFO_LVL <= '0;
    end else begin
      if (wr_accept) wptr <= wptr + PTR_W'(1);
      if (grant_wr)  rptr <= rptr + PTR_W'(1);
      case ({wr_accept, grant_wr})
        2'b10:   WFIFO_LVL <= WFIFO_LVL + LVL_W'(1);
        2'b01:   WFIFO_LVL <= WFIFO_LVL - LVL_W'(1);
        default: WFIFO_LVL <= WFIFO_LVL;
      endcase
    end
  end

  // Tag pipelines tracking which requester owns the data returning from RAM
  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vid_tag0 <= 1'b0;
      vid_tag1 <= 1'b0;
      cpu_tag0 <= 1'b0;
      cpu_tag1 <= 1'b0;
    end else begin
      vid_tag0 <= grant_vid;
      vid_tag1 <= vid_tag0;
      cpu_tag0 <= grant_rd;
      cpu_tag1 <= cpu_tag0;
    end
  end

  // Display read return: fixed two edges after the request is sampled
  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      VID_VALID <= 1'b0;
      VID_DATA  <= '0;
    end else begin
      VID_VALID <= vid_tag1;
      if (vid_tag1) VID_DATA <= RAM_RDATA;
    end
  end

  // CPU handshake: write acceptance or read completion, plus read address latch
  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CPU_ACK   <= 1'b0;
      CPU_RDATA <= '0;
      rd_addr   <= '0;
    end else begin
      CPU_ACK <= wr_accept | rd_done;
      if (rd_accept) rd_addr   <= CPU_ADDR;
      if (rd_done)   CPU_RDATA <= RAM_RDATA;
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: synchronous RAM model, transaction-level
// reference model compared every cycle, and directed literal checks.
module tb_vram_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          PIX_CLK;
  logic          RESET_N;
  logic          VID_RD;
  logic [AW-1:0] VID_ADDR;
  logic [DW-1:0] VID_DATA;
  logic          VID_VALID;
  logic          CPU_REQ;
  logic          CPU_WE;
  logic [AW-1:0] CPU_ADDR;
  logic [DW-1:0] CPU_WDATA;
  logic [DW-1:0] CPU_RDATA;
  logic          CPU_ACK;
  logic [2:0]    WFIFO_LVL;
  logic          RAM_CE;
  logic          RAM_WE;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_WDATA;
  logic [DW-1:0] RAM_RDATA;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  vram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(DEPTH)) dut (
    .PIX_CLK(PIX_CLK), .RESET_N(RESET_N),
    .VID_RD(VID_RD), .VID_ADDR(VID_ADDR), .VID_DATA(VID_DATA), .VID_VALID(VID_VALID),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_RDATA(CPU_RDATA), .CPU_ACK(CPU_ACK), .WFIFO_LVL(WFIFO_LVL),
    .RAM_CE(RAM_CE), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
    .RAM_RDATA(RAM_RDATA)
  );

  initial begin
    PIX_CLK = 1'b0;
    forever #5 PIX_CLK = ~PIX_CLK;
  end

  // Synchronous single-port VRAM
  logic [DW-1:0] ram_mem [0:16383];
  always @(posedge PIX_CLK) begin
    if (RAM_CE) begin
      if (RAM_WE) ram_mem[RAM_ADDR] <= RAM_WDATA;
      else        RAM_RDATA <= ram_mem[RAM_ADDR];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int unsigned due; logic [DW-1:0] data; } sched_t;

  wr_t         wq[$];
  sched_t      vq[$];
  sched_t      cq[$];
  logic [DW-1:0] shadow [0:16383];
  int unsigned cyc = 0;
  int          m_rd = 0;          // 0 idle, 1 waiting for a slot, 2 issued
  logic [AW-1:0] m_rd_addr = '0;
  logic        e_vid_valid = 0, e_ack = 0, e_ce = 0, e_we = 0;
  logic [DW-1:0] e_vid_data = '0, e_rdata = '0, e_wdata = '0;
  logic [AW-1:0] e_addr = '0;
  logic        m_acc, m_wr_acc, m_rd_acc;
  wr_t         m_w;
  sched_t      m_s;

  // Model: one step per clock edge, using only bench-driven inputs
  always @(posedge PIX_CLK) begin
    cyc++;
    if (!RESET_N) begin
      wq.delete(); vq.delete(); cq.delete();
      m_rd = 0; m_rd_addr = '0;
      e_vid_valid = 0; e_vid_data = '0; e_ack = 0; e_rdata = '0;
      e_ce = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    end else begin
      m_acc    = CPU_REQ && !e_ack && (m_rd == 0);
      m_wr_acc = m_acc && CPU_WE && (wq.size() < DEPTH);
      m_rd_acc = m_acc && !CPU_WE;
      e_ce = 0; e_we = 0;
      if (VID_RD) begin
        e_ce = 1; e_addr = VID_ADDR;
        m_s.due = cyc + 2; m_s.data = shadow[VID_ADDR]; vq.push_back(m_s);
      end else if (wq.size() > 0) begin
        m_w = wq.pop_front();
        e_ce = 1; e_we = 1; e_addr = m_w.addr; e_wdata = m_w.data;
        shadow[m_w.addr] = m_w.data;
      end else if (m_rd == 1) begin
        e_ce = 1; e_addr = m_rd_addr; m_rd = 2;
        m_s.due = cyc + 2; m_s.data = shadow[m_rd_addr]; cq.push_back(m_s);
      end
      if (m_wr_acc) begin m_w.addr = CPU_ADDR; m_w.data = CPU_WDATA; wq.push_back(m_w); end
      if (m_rd_acc) begin m_rd = 1; m_rd_addr = CPU_ADDR; end
      e_vid_valid = 0;
      if (vq.size() > 0 && vq[0].due == cyc) begin
        e_vid_valid = 1; e_vid_data = vq[0].data; void'(vq.pop_front());
      end
      e_ack = m_wr_acc;
      if (cq.size() > 0 && cq[0].due == cyc) begin
        e_ack = 1; e_rdata = cq[0].data; void'(cq.pop_front()); m_rd = 0;
      end
    end
  end

  // Compare DUT against the model just after every edge
  always @(posedge PIX_CLK) begin
    #1;
    chk("m_VID_VALID", 32'(VID_VALID), 32'(e_vid_valid));
    chk("m_VID_DATA",  32'(VID_DATA),  32'(e_vid_data));
    chk("m_CPU_ACK",   32'(CPU_ACK),   32'(e_ack));
    chk("m_CPU_RDATA", 32'(CPU_RDATA), 32'(e_rdata));
    chk("m_WFIFO_LVL", 32'(WFIFO_LVL), 32'(wq.size()));
    chk("m_RAM_CE",    32'(RAM_CE),    32'(e_ce));
    chk("m_RAM_WE",    32'(RAM_WE),    32'(e_we));
    chk("m_RAM_ADDR",  32'(RAM_ADDR),  32'(e_addr));
    chk("m_RAM_WDATA", 32'(RAM_WDATA), 32'(e_wdata));
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge PIX_CLK);
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int unsigned lat, output logic [DW-1:0] rd);
    lat = 0;
    CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = a; CPU_WDATA = d;
    do begin
      step();
      lat++;
    end while (!CPU_ACK && lat < 50);
    chk("cpu_ack_seen", 32'(CPU_ACK), 32'd1);
    rd = CPU_RDATA;
    CPU_REQ = 1'b0;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_VID_VALID"}, 32'(VID_VALID), 0);
    chk({tag, "_VID_DATA"},  32'(VID_DATA),  0);
    chk({tag, "_CPU_ACK"},   32'(CPU_ACK),   0);
    chk({tag, "_CPU_RDATA"}, 32'(CPU_RDATA), 0);
    chk({tag, "_WFIFO_LVL"}, 32'(WFIFO_LVL), 0);
    chk({tag, "_RAM_CE"},    32'(RAM_CE),    0);
    chk({tag, "_RAM_WE"},    32'(RAM_WE),    0);
    chk({tag, "_RAM_ADDR"},  32'(RAM_ADDR),  0);
    chk({tag, "_RAM_WDATA"}, 32'(RAM_WDATA), 0);
  endtask

  logic [7:0]  pre_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int unsigned d_lvl [5]    = '{3, 3, 2, 1, 0};
  logic        d_ack [5]    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int unsigned lat;
  logic [DW-1:0] rdv;

  initial begin
    for (int i = 0; i < 16384; i++) begin ram_mem[i] = '0; shadow[i] = '0; end
    for (int i = 0; i < 4; i++) begin ram_mem[i] = pre_data[i]; shadow[i] = pre_data[i]; end
    RAM_RDATA = '0;
    RESET_N = 1'b0; VID_RD = 1'b0; VID_ADDR = '0;
    CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
    step(); step();
    chk_all_zero("reset");
    RESET_N = 1'b1;
    step();

    // Four back-to-back display reads of the preloaded bytes
    for (int unsigned i = 0; i < 7; i++) begin
      VID_RD = (i < 4); VID_ADDR = AW'(i);
      step();
      if (i >= 1) chk("vid_valid_seq", 32'(VID_VALID), 32'(i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) chk("vid_data_seq", 32'(VID_DATA), 32'(pre_data[i-2]));
    end

    // Posted write held off by continuous display reads
    VID_RD = 1'b1; VID_ADDR = 14'h0010;
    cpu_access(1'b1, 14'h3FFF, 8'hA5, lat, rdv);
    chk("wr_ack_latency", lat, 1);
    chk("wr_lvl_1", 32'(WFIFO_LVL), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wr_blocked_we", 32'(RAM_WE), 0);
      chk("wr_blocked_lvl", 32'(WFIFO_LVL), 1);
    end
    VID_RD = 1'b0;
    step();
    chk("wr_slot_we",    32'(RAM_WE), 1);
    chk("wr_slot_addr",  32'(RAM_ADDR), 32'h3FFF);
    chk("wr_slot_wdata", 32'(RAM_WDATA), 32'hA5);
    chk("wr_slot_lvl",   32'(WFIFO_LVL), 0);
    VID_RD = 1'b1; VID_ADDR = 14'h3FFF;
    step();
    VID_RD = 1'b0;
    step(); step();
    chk("raw_vid_valid", 32'(VID_VALID), 1);
    chk("raw_vid_data",  32'(VID_DATA), 32'hA5);

    // FIFO fill to full under display traffic, then drain in order
    VID_RD = 1'b1; VID_ADDR = 14'h0020;
    for (int unsigned k = 0; k < 4; k++) begin
      cpu_access(1'b1, 14'h0200 + AW'(k), 8'h60 + 8'(k), lat, rdv);
      chk("fill_ack_latency", lat, 1);
    end
    chk("fill_lvl_full", 32'(WFIFO_LVL), 4);
    chk("model_lvl_full", wq.size(), 4);
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 14'h0204; CPU_WDATA = 8'h64;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_no_ack", 32'(CPU_ACK), 0);
      chk("full_lvl", 32'(WFIFO_LVL), 4);
    end
    VID_RD = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      step();
      chk("drain_we",    32'(RAM_WE), 1);
      chk("drain_addr",  32'(RAM_ADDR), 32'h200 + k);
      chk("drain_wdata", 32'(RAM_WDATA), 32'h60 + k);
      chk("drain_lvl",   32'(WFIFO_LVL), d_lvl[k]);
      chk("drain_ack",   32'(CPU_ACK), 32'(d_ack[k]));
      if (k == 1) CPU_REQ = 1'b0;
    end
    step();

    // Read-after-write returns the new data
    cpu_access(1'b1, 14'h0100, 8'h5A, lat, rdv);
    chk("raw_wr_latency", lat, 1);
    cpu_access(1'b0, 14'h0100, 8'h00, lat, rdv);
    chk("rd_idle_latency", lat, 4);
    chk("raw_rdata", 32'(rdv), 32'h5A);

    // Display read and CPU read in the same cycle
    VID_RD = 1'b1; VID_ADDR = 14'h0001;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 14'h0002;
    step();
    chk("coll_ack_e0", 32'(CPU_ACK), 0);
    VID_RD = 1'b0;
    step(); step();
    chk("coll_vid_valid", 32'(VID_VALID), 1);
    chk("coll_vid_data",  32'(VID_DATA), 32'h22);
    chk("coll_ack_e2",    32'(CPU_ACK), 0);
    step();
    chk("coll_ack_e3", 32'(CPU_ACK), 1);
    chk("coll_rdata",  32'(CPU_RDATA), 32'h33);
    CPU_REQ = 1'b0;
    step();

    // Reset with queued writes and a pending read
    VID_RD = 1'b1; VID_ADDR = 14'h0001;
    for (int unsigned k = 0; k < 3; k++) begin
      cpu_access(1'b1, 14'h0300 + AW'(k), 8'h70 + 8'(k), lat, rdv);
      chk("rst_fill_latency", lat, 1);
    end
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 14'h0003;
    step();
    chk("rst_rd_no_ack", 32'(CPU_ACK), 0);
    step();
    chk("rst_pre_lvl", 32'(WFIFO_LVL), 3);
    chk("rst_pre_vid", 32'(VID_VALID), 1);
    RESET_N = 1'b0;
    #1;
    chk_all_zero("async_rst");
    CPU_REQ = 1'b0; VID_RD = 1'b0;
    step(); step();
    RESET_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_we",  32'(RAM_WE), 0);
      chk("post_rst_ack", 32'(CPU_ACK), 0);
      chk("post_rst_lvl", 32'(WFIFO_LVL), 0);
    end
    chk("post_rst_mem", 32'(ram_mem[14'h0300]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
